// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the debounce bank.
package debounce_pkg;

   localparam int unsigned DEF_NCH        = 5;
   localparam int unsigned DEF_STABLE_CNT = 50000;
   localparam int unsigned DEF_HOLD_CNT   = 50000000;

   // Bits needed to represent max_val, i.e. ceil(log2(max_val+1)), never below 1.
   function automatic int cnt_width(input longint unsigned max_val);
      int w;
      w = 1;
      while ((64'd1 << w) <= max_val) w++;
      return w;
   endfunction

endpackage

// File: rtl/debounce_if.sv
// Switch inputs and debounced outputs of the bank, one bit per channel.
interface debounce_if
   import debounce_pkg::*;
#(
   parameter int unsigned NCH = DEF_NCH
);

   logic [NCH-1:0] btn_in;
   logic [NCH-1:0] btn_level;
   logic [NCH-1:0] btn_press;
   logic [NCH-1:0] btn_release;
   logic [NCH-1:0] btn_hold;

   modport master (
      output btn_in,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_hold
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_hold
   );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, edge pulses.
// Long-press detection is built only when DEBOUNCE_HOLD_EN is defined.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
   parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int CW = cnt_width(longint'(STABLE_CNT));
   localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   // Counter only runs while the synchronized input disagrees with the accepted level.
   always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == LAST) begin
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= btn_i;
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef DEBOUNCE_HOLD_EN
   localparam int HW = cnt_width(longint'(HOLD_CNT));
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CNT);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          hold_q, hold_d;

   // Saturating at HOLD_MAX makes the pulse fire once per press.
   always_comb begin
      hold_cnt_d = '0;
      hold_d     = 1'b0;
      if (level_q) begin
         if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            hold_d     = (hold_cnt_q == HOLD_MAX - HW'(1));
         end else begin
            hold_cnt_d = hold_cnt_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_cnt_q <= '0;
         hold_q     <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         hold_q     <= hold_d;
      end
   end

   assign hold_o = hold_q;
`else
   localparam int unsigned hold_cnt_unused = HOLD_CNT;

   assign hold_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of NCH independent switch debouncers; DEBOUNCE_HOLD_EN adds long-press pulses.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned NCH        = DEF_NCH,
   parameter int unsigned STABLE_CNT = DEF_STABLE_CNT,
   parameter int unsigned HOLD_CNT   = DEF_HOLD_CNT
) (
   input  logic       clk_50MHz,
   input  logic       reset_n,
   debounce_if.slave  bus
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      debounce_chan #(
         .STABLE_CNT (STABLE_CNT),
         .HOLD_CNT   (HOLD_CNT)
      ) u_chan (
         .clk_i     (clk_50MHz),
         .rst_ni    (reset_n),
         .btn_i     (bus.btn_in[i]),
         .level_o   (bus.btn_level[i]),
         .press_o   (bus.btn_press[i]),
         .release_o (bus.btn_release[i]),
         .hold_o    (bus.btn_hold[i])
      );
   end

endmodule
